// File: rtl/core_test_sequencer.sv
// Bring-up sequencer: holds RISCVCore in reset, streams an image into imem/dmem,
// then runs the core until halt PC or cycle budget. Optional trace buffer: CORE_SEQ_TRACE_EN.
module core_test_sequencer #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int PC_W        = 32,
    parameter int CYCLE_W     = 16,
    parameter int TRACE_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           load_valid,
    output logic                           load_ready,
    input  logic                           load_target,
    input  logic [ADDR_W-1:0]              load_addr,
    input  logic [DATA_W-1:0]              load_data,
    input  logic                           load_last,
    input  logic [CYCLE_W-1:0]             run_cycles,
    input  logic [PC_W-1:0]                halt_pc,
    output logic                           core_rst,
    output logic                           imem_we,
    output logic [ADDR_W-1:0]              imem_addr,
    output logic [DATA_W-1:0]              imem_wdata,
    output logic                           dmem_we,
    output logic [ADDR_W-1:0]              dmem_addr,
    output logic [DATA_W-1:0]              dmem_wdata,
    input  logic [PC_W-1:0]                core_pc,
    input  logic [DATA_W-1:0]              core_instr,
    output logic                           busy,
    output logic                           done,
    output logic                           timeout,
    output logic [CYCLE_W-1:0]             cycle_count,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
    output logic [PC_W-1:0]                trace_pc,
    output logic [DATA_W-1:0]              trace_instr,
    output logic [$clog2(TRACE_DEPTH):0]   trace_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_RELEASE = 3'd2,
        S_RUN     = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                load_ready_q, load_ready_d;
    logic                core_rst_q, core_rst_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                timeout_q, timeout_d;
    logic                imem_we_q, imem_we_d, dmem_we_q, dmem_we_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d, dmem_addr_q, dmem_addr_d;
    logic [DATA_W-1:0]   imem_wdata_q, imem_wdata_d, dmem_wdata_q, dmem_wdata_d;
    logic [CYCLE_W-1:0]  cycle_count_q, cycle_count_d, budget_q, budget_d;
    logic [PC_W-1:0]     halt_q, halt_d;
    logic [CYCLE_W-1:0]  k_s;
    logic                hs_s;

    assign hs_s = load_valid & load_ready_q;
    assign k_s  = cycle_count_q + CYCLE_W'(1);

    // Next-state and registered-output computation
    always_comb begin
        state_d       = state_q;
        done_d        = done_q;
        timeout_d     = timeout_q;
        cycle_count_d = cycle_count_q;
        budget_d      = budget_q;
        halt_d        = halt_q;
        imem_we_d     = 1'b0;
        dmem_we_d     = 1'b0;
        imem_addr_d   = imem_addr_q;
        imem_wdata_d  = imem_wdata_q;
        dmem_addr_d   = dmem_addr_q;
        dmem_wdata_d  = dmem_wdata_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d       = S_LOAD;
                    done_d        = 1'b0;
                    timeout_d     = 1'b0;
                    cycle_count_d = '0;
                end else begin
                    state_d = state_q;
                end
            end
            S_LOAD: begin
                if (hs_s) begin
                    if (load_target) begin
                        dmem_we_d    = 1'b1;
                        dmem_addr_d  = load_addr;
                        dmem_wdata_d = load_data;
                    end else begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = load_addr;
                        imem_wdata_d = load_data;
                    end
                    if (load_last) begin
                        state_d = S_RELEASE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_RELEASE: begin
                budget_d      = run_cycles;
                halt_d        = halt_pc;
                cycle_count_d = '0;
                state_d       = S_RUN;
            end
            S_RUN: begin
                // Saturation only matters for unlimited runs; a budget stops first.
                if (cycle_count_q != {CYCLE_W{1'b1}}) begin
                    cycle_count_d = k_s;
                end else begin
                    cycle_count_d = cycle_count_q;
                end
                if (core_pc == halt_q) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b0;
                end else if ((budget_q != '0) && (k_s == budget_q)) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        load_ready_d = (state_d == S_LOAD);
        busy_d       = (state_d == S_LOAD) || (state_d == S_RELEASE) || (state_d == S_RUN);
        core_rst_d   = (state_d != S_RUN);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            load_ready_q  <= 1'b0;
            core_rst_q    <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
            imem_we_q     <= 1'b0;
            dmem_we_q     <= 1'b0;
            imem_addr_q   <= '0;
            imem_wdata_q  <= '0;
            dmem_addr_q   <= '0;
            dmem_wdata_q  <= '0;
            cycle_count_q <= '0;
            budget_q      <= '0;
            halt_q        <= '0;
        end else begin
            state_q       <= state_d;
            load_ready_q  <= load_ready_d;
            core_rst_q    <= core_rst_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timeout_q     <= timeout_d;
            imem_we_q     <= imem_we_d;
            dmem_we_q     <= dmem_we_d;
            imem_addr_q   <= imem_addr_d;
            imem_wdata_q  <= imem_wdata_d;
            dmem_addr_q   <= dmem_addr_d;
            dmem_wdata_q  <= dmem_wdata_d;
            cycle_count_q <= cycle_count_d;
            budget_q      <= budget_d;
            halt_q        <= halt_d;
        end
    end

    assign load_ready  = load_ready_q;
    assign core_rst    = core_rst_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign imem_we     = imem_we_q;
    assign imem_addr   = imem_addr_q;
    assign imem_wdata  = imem_wdata_q;
    assign dmem_we     = dmem_we_q;
    assign dmem_addr   = dmem_addr_q;
    assign dmem_wdata  = dmem_wdata_q;
    assign cycle_count = cycle_count_q;

`ifdef CORE_SEQ_TRACE_EN
    localparam int TW = $clog2(TRACE_DEPTH);
    localparam logic [TW:0] TR_FULL = TRACE_DEPTH[TW:0];

    logic [PC_W-1:0]   tr_pc_mem    [TRACE_DEPTH];
    logic [DATA_W-1:0] tr_instr_mem [TRACE_DEPTH];
    logic [TW-1:0]     tr_wptr_q;
    logic [TW:0]       tr_count_q;
    logic [TW-1:0]     tr_rd_s;
    logic              tr_run_s, tr_clr_s;

    assign tr_run_s = (state_q == S_RUN);
    assign tr_clr_s = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Trace write pointer and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tr_wptr_q  <= '0;
            tr_count_q <= '0;
        end else if (tr_clr_s) begin
            tr_wptr_q  <= '0;
            tr_count_q <= '0;
        end else if (tr_run_s) begin
            tr_wptr_q  <= tr_wptr_q + TW'(1);
            tr_count_q <= (tr_count_q == TR_FULL) ? tr_count_q : tr_count_q + (TW+1)'(1);
        end else begin
            tr_wptr_q  <= tr_wptr_q;
            tr_count_q <= tr_count_q;
        end
    end

    // Trace storage; occupancy gates reads so contents need no reset
    always_ff @(posedge clk) begin
        if (tr_run_s) begin
            tr_pc_mem[tr_wptr_q]    <= core_pc;
            tr_instr_mem[tr_wptr_q] <= core_instr;
        end
    end

    // Oldest entry sits at the write pointer once the buffer has wrapped
    always_comb begin
        tr_rd_s     = ((tr_count_q == TR_FULL) ? tr_wptr_q : '0) + trace_idx;
        trace_pc    = '0;
        trace_instr = '0;
        if ({1'b0, trace_idx} < tr_count_q) begin
            trace_pc    = tr_pc_mem[tr_rd_s];
            trace_instr = tr_instr_mem[tr_rd_s];
        end else begin
            trace_pc    = '0;
            trace_instr = '0;
        end
    end

    assign trace_count = tr_count_q;
`else
    logic unused_trace_s;
    assign unused_trace_s = ^{trace_idx, core_instr};
    assign trace_pc       = '0;
    assign trace_instr    = '0;
    assign trace_count    = '0;
`endif

endmodule

// File: tb/tb_core_test_sequencer.sv
// Directed self-checking bench for core_test_sequencer with a simple core PC model.
module tb_core_test_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic        load_target = 1'b0;
    logic [9:0]  load_addr = 10'd0;
    logic [31:0] load_data = 32'd0;
    logic        load_last = 1'b0;
    logic [15:0] run_cycles = 16'd0;
    logic [31:0] halt_pc = 32'd0;
    logic        core_rst;
    logic        imem_we, dmem_we;
    logic [9:0]  imem_addr, dmem_addr;
    logic [31:0] imem_wdata, dmem_wdata;
    logic [31:0] core_pc = 32'd0;
    logic [31:0] core_instr;
    logic        busy, done, timeout;
    logic [15:0] cycle_count;
    logic [2:0]  trace_idx = 3'd0;
    logic [31:0] trace_pc, trace_instr;
    logic [3:0]  trace_count;

    int errors = 0;
    int checks = 0;

    core_test_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
        .load_valid(load_valid), .load_ready(load_ready), .load_target(load_target),
        .load_addr(load_addr), .load_data(load_data), .load_last(load_last),
        .run_cycles(run_cycles), .halt_pc(halt_pc), .core_rst(core_rst),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .core_pc(core_pc), .core_instr(core_instr),
        .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count),
        .trace_idx(trace_idx), .trace_pc(trace_pc), .trace_instr(trace_instr),
        .trace_count(trace_count)
    );

    always #5 clk = ~clk;

    // Core model: PC held at 0 in reset, then advances one word per cycle
    always @(posedge clk) begin
        if (core_rst) core_pc <= 32'd0;
        else          core_pc <= core_pc + 32'd4;
    end
    assign core_instr = core_pc ^ 32'h1300_0000;

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic load_word(input logic tgt, input logic [9:0] a, input logic [31:0] d, input logic last);
        load_valid = 1'b1; load_target = tgt; load_addr = a; load_data = d; load_last = last;
        @(negedge clk);
        load_valid = 1'b0; load_last = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL wait_done: done=%b after %0d cycles, required 1", done, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL rst_core_rst: got %b want 1", core_rst); end
        checks++; if ({load_ready, imem_we, dmem_we, busy, done, timeout} !== 6'b0) begin
            errors++; $display("FAIL rst_flags: got %b want 000000", {load_ready, imem_we, dmem_we, busy, done, timeout}); end
        checks++; if (cycle_count !== 16'd0 || trace_count !== 4'd0) begin
            errors++; $display("FAIL rst_counts: cycle_count=%0d trace_count=%0d want 0/0", cycle_count, trace_count); end
        checks++; if ({imem_addr, imem_wdata, dmem_addr, dmem_wdata} !== 84'd0) begin
            errors++; $display("FAIL rst_addr_data: got %h want 0", {imem_addr, imem_wdata, dmem_addr, dmem_wdata}); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_imem_load();
        halt_pc = 32'h14; run_cycles = 16'd0;
        do_start();
        checks++; if (load_ready !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL load_enter: load_ready=%b busy=%b want 1/1", load_ready, busy); end
        for (int i = 0; i < 6; i++) begin
            load_valid = 1'b1; load_target = 1'b0; load_addr = 10'(i);
            load_data = 32'hA000_0000 + 32'(i); load_last = (i == 5);
            @(negedge clk);
            checks++;
            if (imem_we !== 1'b1 || imem_addr !== 10'(i) || imem_wdata !== 32'hA000_0000 + 32'(i)
                || dmem_we !== 1'b0 || core_rst !== 1'b1) begin
                errors++;
                $display("FAIL imem_word%0d: we=%b addr=%0d data=%h dmem_we=%b core_rst=%b want 1/%0d/%h/0/1",
                         i, imem_we, imem_addr, imem_wdata, dmem_we, core_rst, i, 32'hA000_0000 + 32'(i));
            end
        end
        load_valid = 1'b0; load_last = 1'b0;
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL load_ready_after_last: got %b want 0", load_ready); end
    endtask

    task automatic test_halt_run();
        wait_done();
        checks++; if (timeout !== 1'b0 || cycle_count !== 16'd6 || core_rst !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL halt_run: timeout=%b count=%0d core_rst=%b busy=%b want 0/6/1/0",
                               timeout, cycle_count, core_rst, busy); end
    endtask

    task automatic test_dmem_load_and_budget();
        halt_pc = 32'hFFC; run_cycles = 16'd10;
        do_start();
        checks++; if (done !== 1'b0 || cycle_count !== 16'd0) begin
            errors++; $display("FAIL start_clears: done=%b count=%0d want 0/0", done, cycle_count); end
        load_word(1'b1, 10'd2, 32'h1234_5678, 1'b1);
        checks++; if (dmem_we !== 1'b1 || dmem_addr !== 10'd2 || dmem_wdata !== 32'h1234_5678 || imem_we !== 1'b0) begin
            errors++; $display("FAIL dmem_word: we=%b addr=%0d data=%h imem_we=%b want 1/2/12345678/0",
                               dmem_we, dmem_addr, dmem_wdata, imem_we); end
        @(negedge clk);
        checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL dmem_we_pulse: got %b want 0", dmem_we); end
        wait_done();
        checks++; if (timeout !== 1'b1 || cycle_count !== 16'd10) begin
            errors++; $display("FAIL budget_run: timeout=%b count=%0d want 1/10", timeout, cycle_count); end
    endtask

    task automatic test_halt_equals_budget();
        halt_pc = 32'h14; run_cycles = 16'd6;
        do_start();
        load_word(1'b0, 10'd0, 32'h0000_0013, 1'b1);
        wait_done();
        checks++; if (timeout !== 1'b0 || cycle_count !== 16'd6) begin
            errors++; $display("FAIL halt_wins: timeout=%b count=%0d want 0/6", timeout, cycle_count); end
`ifdef CORE_SEQ_TRACE_EN
        trace_idx = 3'd5; #1;
        checks++; if (trace_count !== 4'd6 || trace_pc !== 32'h14) begin
            errors++; $display("FAIL trace_partial: count=%0d pc[5]=%h want 6/14", trace_count, trace_pc); end
        trace_idx = 3'd6; #1;
        checks++; if (trace_pc !== 32'd0 || trace_instr !== 32'd0) begin
            errors++; $display("FAIL trace_beyond_count: pc=%h instr=%h want 0/0", trace_pc, trace_instr); end
`endif
    endtask

    task automatic test_reset_in_run();
        int n = 0;
        halt_pc = 32'hFFC; run_cycles = 16'd0;
        do_start();
        load_word(1'b0, 10'd0, 32'h0000_0013, 1'b1);
        while (cycle_count !== 16'd2 && n < 50) begin @(negedge clk); n++; end
        checks++; if (cycle_count !== 16'd2) begin errors++; $display("FAIL reach_run3: count=%0d want 2", cycle_count); end
        rst = 1'b1; #1;
        checks++; if (core_rst !== 1'b1 || busy !== 1'b0 || cycle_count !== 16'd0 || load_ready !== 1'b0) begin
            errors++; $display("FAIL async_rst: core_rst=%b busy=%b count=%0d load_ready=%b want 1/0/0/0",
                               core_rst, busy, cycle_count, load_ready); end
        @(negedge clk); rst = 1'b0;
        halt_pc = 32'h14;
        do_start();
        checks++; if (load_ready !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL restart_load: load_ready=%b busy=%b want 1/1", load_ready, busy); end
        load_word(1'b0, 10'd1, 32'h0000_0093, 1'b1);
        wait_done();
        checks++; if (timeout !== 1'b0 || cycle_count !== 16'd6) begin
            errors++; $display("FAIL restart_run: timeout=%b count=%0d want 0/6", timeout, cycle_count); end
    endtask

    task automatic test_trace();
        halt_pc = 32'hFFC; run_cycles = 16'd12;
        do_start();
        load_word(1'b0, 10'd0, 32'h0000_0013, 1'b1);
        wait_done();
        checks++; if (timeout !== 1'b1 || cycle_count !== 16'd12) begin
            errors++; $display("FAIL trace_run: timeout=%b count=%0d want 1/12", timeout, cycle_count); end
`ifdef CORE_SEQ_TRACE_EN
        trace_idx = 3'd0; #1;
        checks++; if (trace_count !== 4'd8 || trace_pc !== 32'h10 || trace_instr !== 32'h1300_0010) begin
            errors++; $display("FAIL trace_oldest: count=%0d pc=%h instr=%h want 8/10/13000010",
                               trace_count, trace_pc, trace_instr); end
        trace_idx = 3'd7; #1;
        checks++; if (trace_pc !== 32'h2C || trace_instr !== 32'h1300_002C) begin
            errors++; $display("FAIL trace_newest: pc=%h instr=%h want 2c/1300002c", trace_pc, trace_instr); end
`else
        trace_idx = 3'd0; #1;
        checks++; if (trace_count !== 4'd0 || trace_pc !== 32'd0 || trace_instr !== 32'd0) begin
            errors++; $display("FAIL trace_tied: count=%0d pc=%h instr=%h want 0/0/0", trace_count, trace_pc, trace_instr); end
`endif
    endtask

    initial begin
        test_reset();
        test_imem_load();
        test_halt_run();
        test_dmem_load_and_budget();
        test_halt_equals_budget();
        test_reset_in_run();
        test_trace();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/core_test_sequencer.md
Name: core_test_sequencer

Overview:
Synthesisable bring-up sequencer for RISCVCore. It holds the core in reset and streams a program image into instruction and data memory through a valid/ready port. It then releases the core and counts run cycles until the PC reaches a halt address or a cycle budget expires, and reports pass/timeout status. This replaces ad-hoc bench-side memory poking and fixed-length run loops with a parametrised, reusable block that can be instantiated on FPGA or in simulation.

Parameters:
ADDR_W, 10, word-address width of the imem/dmem write ports
DATA_W, 32, memory word / instruction width
PC_W, 32, core PC width
CYCLE_W, 16, width of run-cycle budget and counter
TRACE_DEPTH, 8, trace buffer entries; power of 2, >=2 (used only with the optional feature)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  pulse: begin load phase (honoured in IDLE/DONE only)
load_valid  in  1  load word present
load_ready  out  1  sequencer accepts load word
load_target  in  1  0 = imem, 1 = dmem
load_addr  in  ADDR_W  word address
load_data  in  DATA_W  word
load_last  in  1  final word of image; qualified by handshake
run_cycles  in  CYCLE_W  cycle budget; 0 = unlimited; sampled at RELEASE
halt_pc  in  PC_W  halt address; sampled at RELEASE
core_rst  out  1  reset to RISCVCore
imem_we / imem_addr / imem_wdata  out  1/ADDR_W/DATA_W  imem write port
dmem_we / dmem_addr / dmem_wdata  out  1/ADDR_W/DATA_W  dmem write port
core_pc  in  PC_W  core PC
core_instr  in  DATA_W  core fetched instruction
busy  out  1  state is LOAD, RELEASE or RUN
done  out  1  run finished; held until next start
timeout  out  1  finished by budget, not halt
cycle_count  out  CYCLE_W  RUN cycles elapsed
trace_idx  in  log2(TRACE_DEPTH)  trace read index, 0 = oldest
trace_pc / trace_instr  out  PC_W/DATA_W  trace entry (combinational read)
trace_count  out  log2(TRACE_DEPTH)+1  valid trace entries

Behaviour:
- Reset (async, immediate):
  - state IDLE; core_rst=1.
  - load_ready, imem_we, dmem_we, busy, done, timeout = 0.
  - cycle_count=0; trace_count=0.
  - All address/data outputs 0.
- FSM states: IDLE, LOAD, RELEASE, RUN, DONE.
- IDLE/DONE:
  - core_rst=1.
  - start -> LOAD; done, timeout and cycle_count are cleared on the same edge.
- LOAD:
  - load_ready=1; core_rst=1.
  - Each handshake (load_valid & load_ready) registers addr/data into the selected port; that port's *_we is high for exactly the next cycle (latency 1). Back-to-back handshakes are accepted every cycle.
  - Handshake with load_last -> RELEASE; load_ready=0 from that edge.
- RELEASE: one cycle.
  - run_cycles and halt_pc are latched; cycle_count=0.
  - core_rst=0 from the next edge.
- RUN: RUN cycle k = 1, 2, ... samples core_pc; cycle_count becomes k at the end of that cycle.
  - core_pc == halt_pc -> DONE, timeout=0.
  - Otherwise, if run_cycles != 0 and k == run_cycles -> DONE, timeout=1.
  - Halt and budget in the same cycle: halt wins, timeout=0.
  - cycle_count saturates at all-ones when the budget is unlimited.
- Entering DONE: done=1 and core_rst=1 on the same edge; counts frozen.
- start during LOAD/RELEASE/RUN is ignored. load_valid outside LOAD is ignored.

Optional Feature:
Macro CORE_SEQ_TRACE_EN.
- Defined: a circular buffer of TRACE_DEPTH {core_pc, core_instr} pairs, written every RUN cycle (including the final one).
  - Cleared on start.
  - trace_count saturates at TRACE_DEPTH.
  - trace_idx 0 = oldest retained entry.
  - Indices >= trace_count read 0.
- Not defined: no storage; trace_pc, trace_instr and trace_count tied to 0.

Test Plan:
1. start, then 6 imem words at addr 0..5 with load_valid every cycle, last on word 5 -> imem_we high 6 consecutive cycles, each one cycle after its handshake, addr 0..5 with matching data; dmem_we=0; core_rst=1 throughout LOAD.
2. dmem word load_addr=2, data 0x12345678 with load_last -> dmem_we one cycle, dmem_addr=2, dmem_wdata=0x12345678; imem_we=0.
3. Core model core_pc=4*(k-1); halt_pc=0x14, run_cycles=0 -> DONE after RUN cycle 6: done=1, timeout=0, cycle_count=6, core_rst=1.
4. halt_pc=0xFFC, run_cycles=10 -> done=1, timeout=1, cycle_count=10. Repeat with halt_pc=0x14, run_cycles=6 -> timeout=0.
5. Assert rst in RUN cycle 3 -> same time step: core_rst=1, busy=0, cycle_count=0, state IDLE. start after release -> normal LOAD.
6. With CORE_SEQ_TRACE_EN, TRACE_DEPTH=8, run 12 cycles -> trace_count=8; trace_idx 0 gives pc 0x10; trace_idx 7 gives pc 0x2C.
